count_display_mux: RTL and testbench



---
 rtl/count_display_mux.sv | 97 +++++++++
 tb/tb_count_display_mux.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/count_display_mux.sv
// Two-digit multiplexed seven-segment driver for a 4-bit count (0..15).
// Snapshots Count once per frame and alternates units/tens on a common-anode display.
module count_display_mux #(
   parameter int REFRESH_DIV = 50000,
   parameter bit BLANK_LZ    = 1'b1
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic [3:0] Count,
   output logic [6:0] Seg,
   output logic [3:0] An,
   output logic       Dp
);

   localparam int             RW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [RW-1:0]  RMAX    = RW'(REFRESH_DIV - 1);
   localparam logic [6:0]     SEG_OFF = 7'b1111111;
   localparam logic [3:0]     AN_OFF  = 4'b1111;
   localparam logic [3:0]     AN_UNIT = 4'b1110;
   localparam logic [3:0]     AN_TENS = 4'b1101;

   typedef enum logic {
      SLOT_UNITS = 1'b0,
      SLOT_TENS  = 1'b1
   } slot_t;

   logic [RW-1:0] rcnt;
   slot_t         sel;
   logic [3:0]    snap;
   logic          tick;
   logic [6:0]    nxt_seg;
   logic [3:0]    nxt_an;

   function automatic logic [6:0] seg_pattern(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return SEG_OFF;
      endcase
   endfunction

   function automatic logic [3:0] units_of(input logic [3:0] v);
      return (v >= 4'd10) ? v - 4'd10 : v;
   endfunction

   function automatic logic [3:0] tens_of(input logic [3:0] v);
      return (v >= 4'd10) ? 4'd1 : 4'd0;
   endfunction

   assign tick = (rcnt == RMAX);
   assign Dp   = 1'b1;

   // Outputs for the slot that starts at the next tick. Leaving the tens slot
   // means a frame start, so the units digit comes from the live Count being snapped.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      nxt_seg = SEG_OFF;
      nxt_an  = AN_OFF;
      if (sel == SLOT_TENS) begin
         nxt_an  = AN_UNIT;
         nxt_seg = seg_pattern(units_of(Count));
      end else if (!BLANK_LZ || tens_of(snap) != 4'd0) begin
         nxt_an  = AN_TENS;
         nxt_seg = seg_pattern(tens_of(snap));
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // sees the pre-edge values of the others.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         rcnt <= '0;
         sel  <= SLOT_TENS;
         snap <= '0;
         Seg  <= SEG_OFF;
         An   <= AN_OFF;
      end else if (tick) begin
         rcnt <= '0;
         sel  <= (sel == SLOT_TENS) ? SLOT_UNITS : SLOT_TENS;
         Seg  <= nxt_seg;
         An   <= nxt_an;
         if (sel == SLOT_TENS)
            snap <= Count;
      end else begin
         rcnt <= rcnt + RW'(1);
      end
   end

endmodule

// File: tb/tb_count_display_mux.sv
// Self-checking bench: two instances (REFRESH_DIV 4 with blanking, 2 without)
// compared every cycle against an edge-count based reference model.
module tb_count_display_mux;

   localparam int DA = 4;
   localparam int DB = 2;

   logic       Clk   = 1'b0;
   logic       Rst   = 1'b0;
   logic [3:0] Count = 4'd0;

   logic [6:0] seg_a, seg_b;
   logic [3:0] an_a, an_b;
   logic       dp_a, dp_b;

   int tests = 0;
   int fails = 0;
   int n      = 0;
   int snap_a = 0;
   int snap_b = 0;

   logic [6:0] pat [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

   always #5 Clk = ~Clk;

   count_display_mux #(.REFRESH_DIV(DA), .BLANK_LZ(1'b1)) dut_a (
      .Clk(Clk), .Rst(Rst), .Count(Count), .Seg(seg_a), .An(an_a), .Dp(dp_a)
   );

   count_display_mux #(.REFRESH_DIV(DB), .BLANK_LZ(1'b0)) dut_b (
      .Clk(Clk), .Rst(Rst), .Count(Count), .Seg(seg_b), .An(an_b), .Dp(dp_b)
   );

   // Expected display after the n-th edge since reset release.
   function automatic void expect_out(input int edges, input int div, input bit blank,
                                      input int snap, output logic [6:0] s,
                                      output logic [3:0] a);
      int slot;
      s = 7'b1111111;
      a = 4'b1111;
      if (edges >= div) begin
         slot = (edges - div) / div;
         if (slot % 2 == 0) begin
            a = 4'b1110;
            s = pat[snap % 10];
         end else if (!(blank && snap / 10 == 0)) begin
            a = 4'b1101;
            s = pat[snap / 10];
         end
      end
   endfunction

   function automatic bit frame_start(input int edges, input int div);
      return edges >= div && (edges - div) % (2 * div) == 0;
   endfunction

   task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s n=%0d count=%0d observed=%b expected=%b", tag, n, Count, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [6:0] es;
      logic [3:0] ea;
      expect_out(n, DA, 1'b1, snap_a, es, ea);
      check_val("seg_a", {1'b0, seg_a}, {1'b0, es});
      check_val("an_a", {4'b0, an_a}, {4'b0, ea});
      check_val("dp_a", {7'b0, dp_a}, 8'd1);
      expect_out(n, DB, 1'b0, snap_b, es, ea);
      check_val("seg_b", {1'b0, seg_b}, {1'b0, es});
      check_val("an_b", {4'b0, an_b}, {4'b0, ea});
      check_val("dp_b", {7'b0, dp_b}, 8'd1);
   endtask

   // One clock: model advances at the rising edge, outputs checked at the falling edge.
   task automatic cycle();
      @(posedge Clk);
      if (!Rst) begin
         n++;
         if (frame_start(n, DA)) snap_a = int'(Count);
         if (frame_start(n, DB)) snap_b = int'(Count);
      end
      @(negedge Clk);
      check_all();
   endtask

   task automatic run(input int cycles);
      for (int i = 0; i < cycles; i++) cycle();
   endtask

   // Assert reset between edges and confirm the display goes dark immediately.
   task automatic async_reset();
      Rst = 1'b1;
      #1;
      n      = 0;
      snap_a = 0;
      snap_b = 0;
      check_all();
   endtask

   initial begin
      Count = 4'($urandom);
      #2;
      async_reset();
      run(2);
      Count = 4'd13;
      run(1);
      Rst = 1'b0;

      // Dark for DA-1 edges, then 13 shown as units 3 / tens 1.
      run(24);

      // Leading-zero blanking on A, explicit zero on B.
      Count = 4'd7;
      run(16);

      // Snapshot coherence: 9 sampled at frame start, 15 applied during units slot.
      for (int guard = 0; guard <= 2 * DA && !frame_start(n + 1, DA); guard++) begin
         cycle();
         if (guard == 2 * DA) check_val("frame_wait", 8'd0, 8'd1);
      end
      Count = 4'd9;
      cycle();
      Count = 4'd15;
      run(2 * DA * 2);

      // Sweep, one frame per value, through 9->10 and 15->0.
      for (int v = 0; v < 16; v++) begin
         Count = 4'(v);
         run(2 * DA);
      end
      Count = 4'd0;
      run(2 * DA);

      // Mid-operation reset during A's tens slot.
      for (int guard = 0; guard <= 2 * DA; guard++) begin
         if (n >= DA && ((n - DA) / DA) % 2 == 1 && (n - DA) % DA == 1) break;
         cycle();
         if (guard == 2 * DA) check_val("tens_wait", 8'd0, 8'd1);
      end
      async_reset();
      Count = 4'd11;
      run(2);
      Rst = 1'b0;
      run(3 * DA);

      // Randomised Count changes at arbitrary points in the frame.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) Count = 4'($urandom);
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
